dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: port 0 (CPU MEM
//  stage) and port 1 (DMA/debug loader). Sequences each access through a
//  3-state FSM and drives the memory's read/write enables, address and write
//  data. Port 0 has fixed priority; an anti-starvation counter guarantees port
//  1 service. Misaligned or out-of-range addresses are rejected without any
//  memory access.
// PARAMETERS
//  MAX_WAIT     4    port-1 arbitration losses before port 1 is forced to win
//  DEPTH_WORDS  256  memory depth in 32-bit words; word index >= this is an error
//  CNT_W        3    width of the port-1 wait counter (must hold MAX_WAIT)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  reset        in   1   asynchronous, active-high reset
//  pN_req       in   1   (N=0,1) access request; held high until pN_ack
//  pN_we        in   1   1=write, 0=read; stable while pN_req high
//  pN_addr      in   32  byte address; stable while pN_req high
//  pN_wdata     in   32  write data; stable while pN_req high
//  pN_ack       out  1   one-cycle completion pulse
//  pN_err       out  1   valid with pN_ack: 1 = access rejected
//  pN_rdata     out  32  read data; valid with pN_ack on a good read
//  mem_read_en  out  1   memory read enable
//  mem_write_en out  1   memory write enable (sampled by memory on clk edge)
//  mem_addr     out  32  memory byte address
//  mem_wdata    out  32  memory write data
//  mem_rdata    in   32  memory combinational read data
//  busy         out  1   high whenever FSM is not IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0; wait counter 0; latched regs 0.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE; error path IDLE -> RESP.
//  IDLE: if any req is high, pick a winner and latch its we/addr/wdata/id.
//   - Winner is port 0 if p0_req, unless p1_req && wait_cnt >= MAX_WAIT.
//   - Good access -> ACCESS. Addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS -> RESP
//     with err=1.
//   - If p1_req loses, wait_cnt increments, saturating at 2^CNT_W-1.
//   - If port 1 wins, wait_cnt clears to 0.
//  ACCESS (1 cycle): mem_addr/mem_wdata = latched values.
//   - mem_write_en = we; mem_read_en = !we.
//   - mem_rdata is captured into the rdata register at the end of the cycle.
//   - Enables are 0 in every other state; mem_addr and mem_wdata are 0 outside
//     ACCESS.
//  RESP (1 cycle): ack of the latched id = 1; err as decided.
//   - pN_rdata = captured data on a good read, 0 on writes and errors.
//   - The other port's ack and err stay 0.
//  Latency: req sampled in IDLE at cycle T -> ack at T+2 (good access) or T+1
//   (error). Back-to-back: a new arbitration occurs in the IDLE cycle after RESP.
//   Max throughput is 1 access per 3 cycles.
//  Requester rule: drop or refresh req in the cycle after ack. If req drops
//   mid-transaction, the access still completes and ack still pulses.
//  Reset mid-transaction: immediate return to IDLE. No ack is issued, enables
//   deassert asynchronously, and a pending write in ACCESS is not performed if
//   reset is high at the edge.
//  Write then read of the same word by the other port: the read observes the
//   new data, because the write commits at the end of its ACCESS cycle.
// TESTING
//  1. p0 write addr=0x10 data=0x12345678, then p0 read 0x10 -> write ack at
//     T+2, mem_write_en high exactly 1 cycle; read ack with rdata=0x12345678, err=0.
//  2. p0 and p1 request simultaneously every cycle -> p0 wins 4 times, then p1
//     wins the 5th arbitration; wait_cnt returns to 0.
//  3. p1 read addr=0x3 -> p1_ack at T+1 with p1_err=1, rdata=0; no mem enable
//     is ever asserted.
//  4. p0 read addr=0x400 (word 256, DEPTH_WORDS=256) -> p0_err=1 at T+1; no
//     memory access.
//  5. Assert reset during ACCESS of a p1 write to 0x20 -> no ack; busy=0;
//     mem_write_en=0; a later read of 0x20 returns the old value.
//  6. Only p1 requests, back-to-back reads of 0x0 and 0x4 -> acks at T+2 and
//     T+5; busy low for exactly 1 cycle between them.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_ack;
    logic        p0_err;
    logic [31:0] p0_rdata;

    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_ack;
    logic        p1_err;
    logic [31:0] p1_rdata;

    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_ack, p0_err, p0_rdata,
        output p1_ack, p1_err, p1_rdata,
        output mem_read_en, mem_write_en, mem_addr, mem_wdata, busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_ack, p0_err, p0_rdata,
        input  p1_ack, p1_err, p1_rdata,
        input  mem_read_en, mem_write_en, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 has priority, port 1
// is guaranteed service after MAX_WAIT losses; bad addresses never reach memory.
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT    = 4,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned CNT_W       = 3
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave io_bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WIDX_W = 30;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              r_state,      w_state_nxt;
    logic [CNT_W-1:0]    r_wait_cnt,   w_wait_cnt_nxt;
    logic                r_we,         w_we_nxt;
    logic                r_id,         w_id_nxt;
    logic                r_err,        w_err_nxt;
    logic [DATA_W-1:0]   r_addr,       w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata,      w_wdata_nxt;

    logic                r_p0_ack,     w_p0_ack_nxt;
    logic                r_p0_err,     w_p0_err_nxt;
    logic [DATA_W-1:0]   r_p0_rdata,   w_p0_rdata_nxt;
    logic                r_p1_ack,     w_p1_ack_nxt;
    logic                r_p1_err,     w_p1_err_nxt;
    logic [DATA_W-1:0]   r_p1_rdata,   w_p1_rdata_nxt;
    logic                r_mem_re,     w_mem_re_nxt;
    logic                r_mem_we,     w_mem_we_nxt;
    logic [DATA_W-1:0]   r_mem_addr,   w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata,  w_mem_wdata_nxt;
    logic                r_busy,       w_busy_nxt;

    logic                w_any_req;
    logic                w_win_p1;
    logic                w_sel_we;
    logic [DATA_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_bad_addr;
    logic [DATA_W-1:0]   w_rdata_cap;

    // Arbitration: port 1 wins when alone or once it has lost MAX_WAIT times
    assign w_any_req   = io_bus.p0_req || io_bus.p1_req;
    assign w_win_p1    = io_bus.p1_req &&
                         (!io_bus.p0_req || (r_wait_cnt >= CNT_W'(MAX_WAIT)));
    assign w_sel_we    = w_win_p1 ? io_bus.p1_we    : io_bus.p0_we;
    assign w_sel_addr  = w_win_p1 ? io_bus.p1_addr  : io_bus.p0_addr;
    assign w_sel_wdata = w_win_p1 ? io_bus.p1_wdata : io_bus.p0_wdata;
    assign w_bad_addr  = (w_sel_addr[1:0] != 2'b00) ||
                         (w_sel_addr[31:2] >= WIDX_W'(DEPTH_WORDS));
    assign w_rdata_cap = ((r_state == ST_ACCESS) && !r_we) ? io_bus.mem_rdata : '0;

    // Next state, latched request and registered outputs for the coming cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_we_nxt       = r_we;
        w_id_nxt       = r_id;
        w_err_nxt      = r_err;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_we_nxt    = w_sel_we;
                    w_id_nxt    = w_win_p1;
                    w_err_nxt   = w_bad_addr;
                    w_addr_nxt  = w_sel_addr;
                    w_wdata_nxt = w_sel_wdata;
                    w_state_nxt = w_bad_addr ? ST_RESP : ST_ACCESS;
                    if (w_win_p1) begin
                        w_wait_cnt_nxt = '0;
                    end else if (io_bus.p1_req && (r_wait_cnt != CNT_MAX)) begin
                        w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                    end
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase

        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        w_mem_re_nxt    = (w_state_nxt == ST_ACCESS) && !w_we_nxt;
        w_mem_we_nxt    = (w_state_nxt == ST_ACCESS) && w_we_nxt;
        w_mem_addr_nxt  = (w_state_nxt == ST_ACCESS) ? w_addr_nxt  : '0;
        w_mem_wdata_nxt = (w_state_nxt == ST_ACCESS) ? w_wdata_nxt : '0;

        w_p0_ack_nxt    = (w_state_nxt == ST_RESP) && !w_id_nxt;
        w_p1_ack_nxt    = (w_state_nxt == ST_RESP) &&  w_id_nxt;
        w_p0_err_nxt    = w_p0_ack_nxt && w_err_nxt;
        w_p1_err_nxt    = w_p1_ack_nxt && w_err_nxt;
        w_p0_rdata_nxt  = w_p0_ack_nxt ? w_rdata_cap : '0;
        w_p1_rdata_nxt  = w_p1_ack_nxt ? w_rdata_cap : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_we        <= 1'b0;
            r_id        <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_p0_ack    <= 1'b0;
            r_p0_err    <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_ack    <= 1'b0;
            r_p1_err    <= 1'b0;
            r_p1_rdata  <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_we        <= w_we_nxt;
            r_id        <= w_id_nxt;
            r_err       <= w_err_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_p0_ack    <= w_p0_ack_nxt;
            r_p0_err    <= w_p0_err_nxt;
            r_p0_rdata  <= w_p0_rdata_nxt;
            r_p1_ack    <= w_p1_ack_nxt;
            r_p1_err    <= w_p1_err_nxt;
            r_p1_rdata  <= w_p1_rdata_nxt;
            r_mem_re    <= w_mem_re_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign io_bus.p0_ack       = r_p0_ack;
    assign io_bus.p0_err       = r_p0_err;
    assign io_bus.p0_rdata     = r_p0_rdata;
    assign io_bus.p1_ack       = r_p1_ack;
    assign io_bus.p1_err       = r_p1_err;
    assign io_bus.p1_rdata     = r_p1_rdata;
    assign io_bus.mem_read_en  = r_mem_re;
    assign io_bus.mem_write_en = r_mem_we;
    assign io_bus.mem_addr     = r_mem_addr;
    assign io_bus.mem_wdata    = r_mem_wdata;
    assign io_bus.busy         = r_busy;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// random two-port traffic, all checked every cycle against a transaction model.
module tb_dmem_arbiter;
    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned DEPTH    = 256;
    localparam int unsigned CNT_SAT  = 7;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    dmem_arbiter_if bus();

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .DEPTH_WORDS(DEPTH), .CNT_W(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory seen by the DUT: combinational read, write on the clock edge
    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
    always @(posedge clk) if (bus.mem_write_en) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endfunction

    function automatic void drive(input bit port, input logic req, input logic we,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end else begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r = $urandom_range(0, 9);
        if (r < 7)  return 32'($urandom_range(0, 15) * 4);
        if (r == 7) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        if (r == 8) return 32'h400 + 32'($urandom_range(0, 255) * 4);
        return $urandom();
    endfunction

    // Transaction model: one access in flight, decided at cycle m_t,
    // touching memory at m_t+1 and answering at m_end.
    bit          m_active = 1'b0;
    int          m_t   = 0;
    int          m_end = 0;
    int          m_cnt = 0;
    bit          m_port, m_we, m_err;
    logic [31:0] m_addr, m_wdata;

    always @(negedge clk) begin
        logic        e_ack0, e_err0, e_ack1, e_err1, e_re, e_we, e_busy;
        logic [31:0] e_rd0, e_rd1, e_addr, e_wdata, e_rd;
        e_ack0 = 0; e_err0 = 0; e_ack1 = 0; e_err1 = 0; e_re = 0; e_we = 0; e_busy = 0;
        e_rd0 = 0; e_rd1 = 0; e_addr = 0; e_wdata = 0; e_rd = 0;
        if (reset) begin
            m_active = 1'b0;
            m_cnt    = 0;
        end else if (m_active) begin
            if (cyc > m_t && cyc <= m_end) e_busy = 1;
            if (!m_err && cyc == m_t + 1) begin
                e_re = !m_we; e_we = m_we; e_addr = m_addr; e_wdata = m_wdata;
            end
            if (cyc == m_end) begin
                e_rd = (!m_err && !m_we) ? ref_mem[m_addr[9:2]] : 32'h0;
                if (m_port) begin e_ack1 = 1; e_err1 = m_err; e_rd1 = e_rd; end
                else        begin e_ack0 = 1; e_err0 = m_err; e_rd0 = e_rd; end
            end
        end
        chk("p0_ack",       32'(bus.p0_ack),       32'(e_ack0));
        chk("p0_err",       32'(bus.p0_err),       32'(e_err0));
        chk("p0_rdata",     bus.p0_rdata,          e_rd0);
        chk("p1_ack",       32'(bus.p1_ack),       32'(e_ack1));
        chk("p1_err",       32'(bus.p1_err),       32'(e_err1));
        chk("p1_rdata",     bus.p1_rdata,          e_rd1);
        chk("mem_read_en",  32'(bus.mem_read_en),  32'(e_re));
        chk("mem_write_en", 32'(bus.mem_write_en), 32'(e_we));
        chk("mem_addr",     bus.mem_addr,          e_addr);
        chk("mem_wdata",    bus.mem_wdata,         e_wdata);
        chk("busy",         32'(bus.busy),         32'(e_busy));
        if (!reset) begin
            if (m_active && !m_err && m_we && cyc == m_t + 1) ref_mem[m_addr[9:2]] = m_wdata;
            if ((!m_active || cyc > m_end) && (bus.p0_req || bus.p1_req)) begin
                m_port  = bus.p1_req && (!bus.p0_req || m_cnt >= int'(MAX_WAIT));
                m_we    = m_port ? bus.p1_we    : bus.p0_we;
                m_addr  = m_port ? bus.p1_addr  : bus.p0_addr;
                m_wdata = m_port ? bus.p1_wdata : bus.p0_wdata;
                m_err   = ((m_addr % 4) != 0) || ((m_addr >> 2) >= 32'(DEPTH));
                m_t     = cyc;
                m_end   = cyc + (m_err ? 1 : 2);
                m_active = 1'b1;
                if (m_port) m_cnt = 0;
                else if (bus.p1_req && m_cnt < int'(CNT_SAT)) m_cnt++;
            end
        end
    end

    // Single request from an idle arbiter; reports latency to ack and enable activity
    task automatic do_req(input bit port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic err,
                          output logic [31:0] rdata, output int we_cyc, output int en_cyc);
        int t0;
        @(posedge clk); #1;
        drive(port, 1'b1, we, addr, wdata);
        t0 = cyc;
        lat = -1; err = 1'b0; rdata = '0; we_cyc = 0; en_cyc = 0;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            @(negedge clk);
            if (bus.mem_write_en) we_cyc++;
            if (bus.mem_write_en || bus.mem_read_en) en_cyc++;
            if (port ? bus.p1_ack : bus.p0_ack) begin
                lat   = cyc - t0;
                err   = port ? bus.p1_err   : bus.p0_err;
                rdata = port ? bus.p1_rdata : bus.p0_rdata;
            end
        end
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        int          lat, we_cyc, en_cyc, t0, a1, a2, idle_between, nack, late_acks;
        logic        err, ack0, ack1;
        logic [31:0] rdata;
        logic [9:0]  order;
        bit          pend0, pend1, refresh;

        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]     = $urandom();
            ref_mem[i] = mem[i];
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'h0);

        // Write then read back the same word on port 0
        do_req(1'b0, 1'b1, 32'h10, 32'h1234_5678, lat, err, rdata, we_cyc, en_cyc);
        chk("t1 write latency", 32'(lat), 32'd2);
        chk("t1 write_en cycles", 32'(we_cyc), 32'd1);
        chk("t1 write err", 32'(err), 32'h0);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, lat, err, rdata, we_cyc, en_cyc);
        chk("t1 read latency", 32'(lat), 32'd2);
        chk("t1 read rdata", rdata, 32'h1234_5678);
        chk("t1 read err", 32'(err), 32'h0);

        // Misaligned port-1 read
        do_req(1'b1, 1'b0, 32'h3, 32'h0, lat, err, rdata, we_cyc, en_cyc);
        chk("t3 latency", 32'(lat), 32'd1);
        chk("t3 err", 32'(err), 32'h1);
        chk("t3 rdata", rdata, 32'h0);
        chk("t3 enables", 32'(en_cyc), 32'd0);

        // Word index 256 is past the end
        do_req(1'b0, 1'b0, 32'h400, 32'h0, lat, err, rdata, we_cyc, en_cyc);
        chk("t4 latency", 32'(lat), 32'd1);
        chk("t4 err", 32'(err), 32'h1);
        chk("t4 enables", 32'(en_cyc), 32'd0);

        // Both ports request continuously: port 1 gets every fifth grant
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        order = '0; nack = 0;
        for (int k = 0; k < 60 && nack < 10; k++) begin
            @(negedge clk);
            if (bus.p0_ack) nack++;
            if (bus.p1_ack) begin order[nack] = 1'b1; nack++; end
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("t2 ack count", 32'(nack), 32'd10);
        chk("t2 winner order", 32'(order), 32'h0000_0210);

        // Reset in the middle of a port-1 write's memory cycle
        do_req(1'b0, 1'b1, 32'h20, 32'hA5A5_0020, lat, err, rdata, we_cyc, en_cyc);
        chk("t5 setup latency", 32'(lat), 32'd2);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        chk("t5 busy", 32'(bus.busy), 32'h0);
        chk("t5 write_en", 32'(bus.mem_write_en), 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        late_acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.p1_ack || bus.p0_ack) late_acks++;
        end
        chk("t5 no ack after reset", 32'(late_acks), 32'd0);
        do_req(1'b0, 1'b0, 32'h20, 32'h0, lat, err, rdata, we_cyc, en_cyc);
        chk("t5 old value", rdata, 32'hA5A5_0020);

        // Port 1 alone, back-to-back reads
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        t0 = cyc; a1 = -1; a2 = -1; idle_between = 0;
        for (int k = 0; k < 20 && a2 < 0; k++) begin
            @(negedge clk);
            refresh = 1'b0;
            if (a1 >= 0 && !bus.busy) idle_between++;
            if (bus.p1_ack) begin
                if (a1 < 0) begin a1 = cyc - t0; refresh = 1'b1; end
                else a2 = cyc - t0;
            end
            if (refresh) begin
                @(posedge clk); #1;
                drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
            end
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("t6 first ack", 32'(a1), 32'd2);
        chk("t6 second ack", 32'(a2), 32'd5);
        chk("t6 idle gap", 32'(idle_between), 32'd1);

        // Random traffic on both ports; requests held until acked
        pend0 = 1'b0; pend1 = 1'b0;
        for (int k = 0; k < 2400; k++) begin
            @(negedge clk);
            ack0 = bus.p0_ack;
            ack1 = bus.p1_ack;
            @(posedge clk); #1;
            if (pend0 && ack0) begin pend0 = 1'b0; drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); end
            if (pend1 && ack1) begin pend1 = 1'b0; drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0); end
            if (!pend0 && $urandom_range(0, 2) != 0) begin
                pend0 = 1'b1;
                drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
            end
            if (!pend1 && $urandom_range(0, 1) != 0) begin
                pend1 = 1'b1;
                drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
